// File: rtl/manchester_pkg.sv
// Shared types and timing helpers for the Manchester receive path.
// Window and timeout helpers are expressed in system clocks for a given oversample ratio.
package manchester_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StData
  } state_e;

  localparam int unsigned OVERSAMPLE_DEF = 8;
  localparam int unsigned DATA_W_DEF     = 8;

  function automatic int unsigned win_lo(input int unsigned os);
    return (3 * os) / 4;
  endfunction

  function automatic int unsigned win_hi(input int unsigned os);
    return (5 * os) / 4;
  endfunction

  function automatic int unsigned tmo(input int unsigned os);
    return (5 * os) / 4 + 1;
  endfunction

endpackage

// File: rtl/manchester_edge_sync.sv
// Two-flop synchronizer plus one delay flop; reports the synchronized level and its edges.
module manchester_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~dly_q;
  assign fall_o  = ~sync2_q & dly_q;

endmodule

// File: rtl/manchester_rx.sv
// Oversampling Manchester (IEEE 802.3) frame decoder with mid-bit acceptance window and
// mid-frame timeout.
module manchester_rx
  import manchester_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(5 * OVERSAMPLE / 4 + 2);
  localparam int unsigned BitW = $clog2(DATA_W + 1);

  localparam logic [CntW-1:0] CntArm = CntW'(OVERSAMPLE);
  localparam logic [CntW-1:0] WinLo  = CntW'(win_lo(OVERSAMPLE));
  localparam logic [CntW-1:0] WinHi  = CntW'(win_hi(OVERSAMPLE));
  localparam logic [CntW-1:0] Tmo    = CntW'(tmo(OVERSAMPLE));
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  logic level, rise, fall, edge_det;

  manchester_edge_sync u_edge_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (rx_i),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign edge_det = rise | fall;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (!en_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      bitcnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // cnt doubles as the quiet-line detector; a start edge is only trusted once armed.
          if (level) begin
            cnt_d = '0;
          end else if (cnt_q != CntArm) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if ((cnt_q == CntArm) && rise) begin
            state_d  = StData;
            cnt_d    = '0;
            bitcnt_d = '0;
          end
        end

        StData: begin
          cnt_d = cnt_q + CntW'(1);
          if (edge_det && (cnt_q >= WinLo) && (cnt_q <= WinHi)) begin
            shift_d  = {shift_q[DATA_W-2:0], level};
            bitcnt_d = bitcnt_q + BitW'(1);
            cnt_d    = '0;
            if (bitcnt_q == LastBit) begin
              data_d  = {shift_q[DATA_W-2:0], level};
              valid_d = 1'b1;
              state_d = StIdle;
            end
          end else if (cnt_q == Tmo) begin
            err_d   = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q == StData);

endmodule
